// File: rtl/rv32i_mmu_if.sv
// Core-side and target-side signal bundle for the RV32I memory-management block.
// The MMU uses the slave modport; the core/target side uses the master modport.
interface rv32i_mmu_if;
  logic [31:0] im_addr;
  logic [31:0] im_do;
  logic [9:0]  im_addr_out;
  logic [31:0] im_data;
  logic [31:0] dm_addr;
  logic [31:0] dm_di;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic        is_signed;
  logic [31:0] dm_do;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_read;
  logic [31:0] io_data_write;

  modport slave (
    input  im_addr, im_data, dm_addr, dm_di, dm_we, dm_be, is_signed, io_data_read,
    output im_do, im_addr_out, dm_do, io_addr, io_en, io_we, io_data_write
  );

  modport master (
    output im_addr, im_data, dm_addr, dm_di, dm_we, dm_be, is_signed, io_data_read,
    input  im_do, im_addr_out, dm_do, io_addr, io_en, io_we, io_data_write
  );
endinterface

// File: rtl/rv32i_mmu.sv
// Region decode, store lane alignment and load extraction between the RV32I core,
// the instruction ROM, a 4 KiB internal data RAM and the 256-byte I/O window.
module rv32i_mmu (
  input  logic        clk,
  input  logic        resetb,
  rv32i_mmu_if.slave  bus
);

  typedef enum logic [1:0] {RegNone, RegRam, RegIo} region_e;

  logic        ram_sel, io_sel, aligned, ram_we;
  logic [4:0]  lane_shift;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [9:0]  ram_idx;
  logic [31:0] mem [1024];
  logic [31:0] ram_rdata_q;
  region_e     region_d, region_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic        signed_q;
  logic [31:0] io_rdata_q;
  logic [31:0] src, shifted;
  logic        unused_fetch;

  // ROM aliases every 4 KiB, so only the word offset within it matters.
  assign bus.im_addr_out = bus.im_addr[11:2];
  assign bus.im_do       = bus.im_data;
  assign unused_fetch    = ^{bus.im_addr[31:12], bus.im_addr[1:0]};

  assign ram_sel    = (bus.dm_addr[31:12] == 20'h00001);
  assign io_sel     = (bus.dm_addr[31:8] == 24'hFFFFFF);
  assign ram_idx    = bus.dm_addr[11:2];
  assign lane_shift = {bus.dm_addr[1:0], 3'b000};
  assign wdata      = bus.dm_di << lane_shift;
  assign wmask      = bus.dm_be << bus.dm_addr[1:0];

  always_comb begin
    aligned = 1'b0;
    case (bus.dm_be)
      4'b0001: aligned = 1'b1;
      4'b0011: aligned = ~bus.dm_addr[0];
      4'b1111: aligned = (bus.dm_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    region_d = RegNone;
    if (aligned && ram_sel)     region_d = RegRam;
    else if (aligned && io_sel) region_d = RegIo;
  end

  assign ram_we            = bus.dm_we & ram_sel & aligned & ~resetb;
  assign bus.io_addr       = bus.dm_addr[7:0];
  assign bus.io_en         = io_sel & aligned & ~resetb;
  assign bus.io_we         = bus.io_en & bus.dm_we;
  assign bus.io_data_write = wdata;

  // Single port, read-before-write: the read captures the pre-store word.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    ram_rdata_q <= mem[ram_idx];
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      region_q   <= RegNone;
      off_q      <= 2'b00;
      be_q       <= 4'b0000;
      signed_q   <= 1'b0;
      io_rdata_q <= 32'h0;
    end else begin
      region_q   <= region_d;
      off_q      <= bus.dm_addr[1:0];
      be_q       <= bus.dm_be;
      signed_q   <= bus.is_signed;
      io_rdata_q <= bus.io_data_read;
    end
  end

  always_comb begin
    src = 32'h0;
    case (region_q)
      RegRam:  src = ram_rdata_q;
      RegIo:   src = io_rdata_q;
      default: src = 32'h0;
    endcase
  end

  assign shifted = src >> {off_q, 3'b000};

  always_comb begin
    bus.dm_do = shifted;
    case (be_q)
      4'b0001: bus.dm_do = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      4'b0011: bus.dm_do = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: bus.dm_do = shifted;
    endcase
  end

endmodule

// File: tb/tb_rv32i_mmu.sv
// Directed bench for rv32i_mmu: loads are scored through an expected-value queue
// drained by a monitor; combinational fetch and I/O outputs are checked inline.
module tb_rv32i_mmu;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic resetb;
  logic ld_issue;
  logic rsp_valid;
  int   checks;
  int   errors;
  exp_t sb[$];

  rv32i_mmu_if bus ();

  rv32i_mmu dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle's data-side inputs 2 time units after the edge; a load pushes its
  // expected value so the monitor can compare once the result is presented.
  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic we,
                    input logic [3:0] be, input logic sg, input logic [31:0] ior,
                    input logic ld, input logic [31:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #2;
    bus.dm_addr      = a;
    bus.dm_di        = d;
    bus.dm_we        = we;
    bus.dm_be        = be;
    bus.is_signed    = sg;
    bus.io_data_read = ior;
    ld_issue         = ld;
    if (ld) begin
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    op(a, d, 1'b1, be, 1'b0, 32'h0, 1'b0, 32'h0, "");
  endtask

  task automatic ld(input logic [31:0] a, input logic [3:0] be, input logic sg,
                    input logic [31:0] ior, input logic [31:0] exp, input string name);
    op(a, 32'h0, 1'b0, be, sg, ior, 1'b1, exp, name);
  endtask

  always @(posedge clk) rsp_valid <= ld_issue;

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got 0x%08h expected no response", bus.dm_do);
      end else begin
        e = sb.pop_front();
        chk(e.name, bus.dm_do, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    resetb = 1'b1;
    ld_issue = 1'b0;
    bus.im_addr = 32'h0;
    bus.im_data = 32'h0;
    bus.dm_addr = 32'h0;
    bus.dm_di = 32'h0;
    bus.dm_we = 1'b0;
    bus.dm_be = 4'b1111;
    bus.is_signed = 1'b0;
    bus.io_data_read = 32'h0;

    #1;
    chk("rst_dm_do", bus.dm_do, 32'h0);
    chk("rst_io_en", {31'h0, bus.io_en}, 32'h0);

    bus.im_addr = 32'h0000_0008;
    bus.im_data = 32'h0000_0013;
    #1;
    chk("fetch_addr", {22'h0, bus.im_addr_out}, 32'h2);
    chk("fetch_data", bus.im_do, 32'h0000_0013);
    bus.im_addr = 32'h0000_3FFC;
    bus.im_data = 32'hA5A5_0FF0;
    #1;
    chk("fetch_alias", {22'h0, bus.im_addr_out}, 32'h3FF);
    chk("fetch_data2", bus.im_do, 32'hA5A5_0FF0);

    @(posedge clk);
    #2;
    resetb = 1'b0;

    st(32'h1000, 32'h1111_2222, 4'b1111);
    #1;
    chk("ram_st_io_en", {31'h0, bus.io_en}, 32'h0);
    st(32'h1004, 32'hDEAD_BEEF, 4'b1111);
    st(32'h1008, 32'h0000_0000, 4'b1111);
    st(32'h1009, 32'h0000_0080, 4'b0001);
    ld(32'h1004, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, "ld_word");
    ld(32'h1004, 4'b1111, 1'b1, 32'h0, 32'hDEAD_BEEF, "ld_word_sgn");
    ld(32'h1009, 4'b0001, 1'b1, 32'h0, 32'hFFFF_FF80, "ld_byte_s");
    ld(32'h1009, 4'b0001, 1'b0, 32'h0, 32'h0000_0080, "ld_byte_u");
    ld(32'h1008, 4'b0011, 1'b0, 32'h0, 32'h0000_8000, "ld_half_u");
    ld(32'h1008, 4'b0011, 1'b1, 32'h0, 32'hFFFF_8000, "ld_half_s");
    ld(32'h1007, 4'b0001, 1'b0, 32'h0, 32'h0000_00DE, "ld_byte3_u");
    ld(32'h1006, 4'b0001, 1'b1, 32'h0, 32'hFFFF_FFAD, "ld_byte2_s");
    ld(32'h1006, 4'b0011, 1'b0, 32'h0, 32'h0000_DEAD, "ld_half_hi");

    st(32'hFFFF_FF10, 32'h0000_1234, 4'b1111);
    #1;
    chk("io_en", {31'h0, bus.io_en}, 32'h1);
    chk("io_we", {31'h0, bus.io_we}, 32'h1);
    chk("io_addr", {24'h0, bus.io_addr}, 32'h10);
    chk("io_wdata", bus.io_data_write, 32'h0000_1234);
    st(32'hFFFF_FF13, 32'h0000_00AB, 4'b0001);
    #1;
    chk("io_wdata_b3", bus.io_data_write, 32'hAB00_0000);
    chk("io_we_b3", {31'h0, bus.io_we}, 32'h1);
    st(32'hFFFF_FF11, 32'h0000_5678, 4'b0011);
    #1;
    chk("io_mis_en", {31'h0, bus.io_en}, 32'h0);
    chk("io_mis_we", {31'h0, bus.io_we}, 32'h0);
    ld(32'hFFFF_FF08, 4'b1111, 1'b0, 32'h0000_1002, 32'h0000_1002, "ld_io_word");
    ld(32'hFFFF_FF09, 4'b0001, 1'b1, 32'h0000_F000, 32'hFFFF_FFF0, "ld_io_byte_s");

    st(32'h1002, 32'hCAFE_F00D, 4'b1111);
    #1;
    chk("mis_st_io_we", {31'h0, bus.io_we}, 32'h0);
    ld(32'h1000, 4'b1111, 1'b0, 32'h0, 32'h1111_2222, "mis_keep0");
    ld(32'h1004, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, "mis_keep4");
    ld(32'h1002, 4'b1111, 1'b0, 32'h0, 32'h0, "ld_mis_word");
    ld(32'h1001, 4'b0011, 1'b0, 32'h0, 32'h0, "ld_mis_half");
    ld(32'h1004, 4'b0111, 1'b0, 32'h0, 32'h0, "ld_bad_be");
    ld(32'h2000_0000, 4'b1111, 1'b0, 32'h0, 32'h0, "ld_unmapped");
    st(32'h2000_0000, 32'h9999_9999, 4'b1111);

    st(32'h100C, 32'hAAAA_5555, 4'b1111);
    op(32'h100C, 32'h1234_5678, 1'b1, 4'b1111, 1'b0, 32'h0, 1'b1, 32'hAAAA_5555, "rbw_old");
    ld(32'h100C, 4'b1111, 1'b0, 32'h0, 32'h1234_5678, "rbw_new");

    ld(32'h1004, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, "pre_rst_ld");
    op(32'h1004, 32'h0, 1'b0, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, "");
    @(posedge clk);
    #2;
    resetb = 1'b1;
    bus.dm_addr = 32'h1000;
    bus.dm_di = 32'h55AA_55AA;
    bus.dm_we = 1'b1;
    bus.dm_be = 4'b1111;
    #1;
    chk("rst_async_do", bus.dm_do, 32'h0);
    @(posedge clk);
    #2;
    bus.dm_addr = 32'hFFFF_FF10;
    #1;
    chk("rst_io_en_blk", {31'h0, bus.io_en}, 32'h0);
    chk("rst_io_we_blk", {31'h0, bus.io_we}, 32'h0);
    @(posedge clk);
    #2;
    resetb = 1'b0;
    bus.dm_we = 1'b0;
    ld(32'h1000, 4'b1111, 1'b0, 32'h0, 32'h1111_2222, "post_rst_1000");
    ld(32'h1004, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, "post_rst_1004");
    op(32'h0, 32'h0, 1'b0, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, "");

    repeat (3) @(posedge clk);
    #6;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_mmu.md
# rv32i_mmu

Memory-management and address-decode block for the embedded RV32I soft core. It sits between the core's instruction and data ports and three targets: the external instruction ROM, a 4 KiB internal data RAM, and the 256-byte memory-mapped I/O bus. It performs region decode, byte-lane alignment for stores, and byte/half/word extraction with sign extension for loads.

## Interface
- No parameters; memory map fixed as below.
- clk  in  1  system clock, all state on rising edge
- resetb  in  1  reset, asynchronous, active-high (name kept per codebase)
- im_addr  in  32  core fetch byte address
- im_do  out  32  instruction word to core
- im_addr_out  out  10 [11:2]  word address to external instruction ROM
- im_data  in  32  ROM read data
- dm_addr  in  32  core data byte address
- dm_di  in  32  store data, right-aligned
- dm_we  in  1  store strobe
- dm_be  in  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word, right-aligned
- is_signed  in  1  sign-extend byte/half loads
- dm_do  out  32  load data to core, right-aligned and extended
- io_addr  out  8  I/O byte address
- io_en  out  1  I/O region selected
- io_we  out  1  I/O write strobe
- io_data_read  in  32  I/O read word
- io_data_write  out  32  I/O write word, lane-aligned

## Operation
- Fetch path combinational: im_addr_out = im_addr[11:2]; im_do = im_data. Upper fetch bits ignored (ROM aliases every 4 KiB).
- Data map: 0x0000_1000–0x0000_1FFF internal RAM (1024×32, word index dm_addr[11:2]); 0xFFFF_FF00–0xFFFF_FFFF I/O; all else unmapped.
- Lane placement: store word = dm_di << (8·dm_addr[1:0]); byte mask = dm_be << dm_addr[1:0].
- Misaligned: half with dm_addr[0]=1, or word with dm_addr[1:0]≠0 → store suppressed (RAM and I/O), load returns 0.
- Invalid dm_be (any value other than the three listed) treated as misaligned.
- RAM store: on rising clk when dm_we, RAM region, aligned, not in reset; only masked bytes written.
- I/O: io_addr = dm_addr[7:0]; io_en = I/O region & aligned & not reset; io_we = io_en & dm_we; io_data_write = lane-shifted store word.
- Load: selected source word (RAM word, io_data_read, or 0 if unmapped) shifted right by 8·dm_addr[1:0], masked to size; if is_signed, bit 7 (byte) or bit 15 (half) replicated; word loads ignore is_signed.
- Unmapped stores ignored; unmapped loads return 0.

## Timing
- Fetch: zero latency, combinational.
- Data load: one-cycle latency. Address, dm_be, is_signed, region and offset registered at rising clk; dm_do valid the following cycle and held until next edge.
- RAM read and write share one port; a same-cycle read of a written address returns old data (read-before-write).
- Store: takes effect at the rising edge where dm_we is high; io_we asserted combinationally for that cycle only.
- Reset: dm_do = 0 and load pipeline registers cleared asynchronously; io_en = io_we = 0; RAM writes blocked; RAM contents not cleared. First valid load data one cycle after reset deassertion.

## Test plan
- Fetch: im_addr=0x0000_0008, im_data=0x0000_0013 → im_addr_out=2, im_do=0x0000_0013 same cycle.
- Word store/load: store 0xDEAD_BEEF to 0x1004 (be=1111), then load 0x1004 → dm_do=0xDEAD_BEEF one cycle after load address.
- Byte/half: store byte 0x80 to 0x1009; signed byte load 0x1009 → 0xFFFF_FF80, unsigned → 0x0000_0080; unsigned half load 0x1008 → 0x0000_8000 given word was 0.
- I/O: store 0x1234 word to 0xFFFF_FF10 → io_en=1, io_we=1, io_addr=0x10, io_data_write=0x0000_1234; load 0xFFFF_FF08 with io_data_read=0x1002 → dm_do=0x0000_1002 next cycle.
- Misaligned/unmapped: word store to 0x1002 → RAM unchanged, io_we=0; load 0x2000_0000 → dm_do=0.
- Reset mid-operation: assert resetb during store to 0x1000 → RAM unchanged, dm_do=0 immediately, io_en=0; after release, load 0x1004 still returns earlier contents.
